// File: rtl/fsm1011_seq_ctrl.sv
// fsm1011_seq_ctrl: accepts an 8-bit word and scans it MSB-first through a
// Mealy "1011" detector, one bit per clock. It counts the matches and
// presents the count with a valid/ready handshake.
module fsm1011_seq_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic       cfg_overlap,
  input  logic       cfg_carry,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_count,
  output logic       out_hit,
  output logic       ser_x,
  output logic       ser_y
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} ctrl_e;
  typedef enum logic [1:0] {S0, S1, S10, S101} det_e;

  ctrl_e      state, state_nx;
  det_e       det, det_nx;
  logic [7:0] data_q;
  logic       ovl_q;
  logic [2:0] idx;
  logic [3:0] cnt;
  logic       accept;

  // Controller state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // Controller next state and handshake decode.
  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    case (state)
      IDLE:  if (in_valid) begin
               accept   = 1'b1;
               state_nx = SHIFT;
             end
      SHIFT: if (idx == 3'd0) state_nx = DONE;
      DONE:  if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Output decode. in_ready is gated by reset because the reset state is
  // IDLE, but the block must not advertise readiness while reset is held.
  always_comb begin
    in_ready  = (state == IDLE) && rst;
    out_valid = (state == DONE);
    out_count = cnt;
    out_hit   = (cnt != 4'd0);
  end

  // Detector state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) det <= S0;
    else      det <= det_nx;
  end

  // Mealy "1011" detector. It advances only while shifting. On accept it is
  // cleared unless the new word asks to carry the state over.
  always_comb begin
    det_nx = det;
    ser_y  = 1'b0;
    ser_x  = (state == SHIFT) ? data_q[idx] : 1'b0;
    if (accept && !cfg_carry) begin
      det_nx = S0;
    end else if (state == SHIFT) begin
      case (det)
        S0:   det_nx = ser_x ? S1 : S0;
        S1:   det_nx = ser_x ? S1 : S10;
        S10:  det_nx = ser_x ? S101 : S0;
        S101: begin
          if (ser_x) begin
            ser_y  = 1'b1;
            det_nx = ovl_q ? S1 : S0;
          end else begin
            det_nx = S10;
          end
        end
        default: det_nx = S0;
      endcase
    end
  end

  // Word capture, bit index and match counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q <= 8'd0;
      ovl_q  <= 1'b0;
      idx    <= 3'd7;
      cnt    <= 4'd0;
    end else if (accept) begin
      data_q <= in_data;
      ovl_q  <= cfg_overlap;
      idx    <= 3'd7;
      cnt    <= 4'd0;
    end else if (state == SHIFT) begin
      idx <= idx - 3'd1;
      // An 8-bit word holds at most three matches, so this guard never
      // limits the count. It keeps the counter from wrapping regardless.
      if (ser_y && cnt != 4'hF) cnt <= cnt + 4'd1;
    end
  end

endmodule

// File: tb/tb_fsm1011_seq_ctrl.sv
// Directed bench for fsm1011_seq_ctrl. Inputs are driven and outputs are
// sampled 1 time unit after each rising edge.
module tb_fsm1011_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = 8'd0;
  logic       cfg_overlap = 1'b0;
  logic       cfg_carry = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [3:0] out_count;
  logic       out_hit;
  logic       ser_x;
  logic       ser_y;

  int checks = 0;
  int errors = 0;

  fsm1011_seq_ctrl dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .cfg_overlap(cfg_overlap), .cfg_carry(cfg_carry),
    .out_valid(out_valid), .out_ready(out_ready), .out_count(out_count),
    .out_hit(out_hit), .ser_x(ser_x), .ser_y(ser_y)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accept one word, let it shift for 8 edges and stop in DONE without
  // popping the result. The number of ser_y pulses seen must equal exp.
  task automatic start_word(input string tag, input logic [7:0] d,
                            input logic ov, input logic ca, input int exp);
    int ys;
    ys = 0;
    check({tag, ":in_ready"}, in_ready, 1'b1);
    in_data = d; cfg_overlap = ov; cfg_carry = ca; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check({tag, ":busy"}, in_ready, 1'b0);
    for (int i = 0; i < 8; i++) begin
      if (ser_y === 1'b1) ys++;
      check({tag, ":no_valid_early"}, out_valid, 1'b0);
      step();
    end
    check({tag, ":ser_y_pulses"}, ys[7:0], exp[7:0]);
    check({tag, ":out_valid"}, out_valid, 1'b1);
    check({tag, ":out_count"}, {4'd0, out_count}, exp[7:0]);
    check({tag, ":out_hit"}, out_hit, exp != 0);
    check({tag, ":ser_y_done"}, ser_y, 1'b0);
  endtask

  task automatic pop(input string tag);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({tag, ":popped"}, out_valid, 1'b0);
    check({tag, ":idle"}, in_ready, 1'b1);
  endtask

  task automatic run_word(input string tag, input logic [7:0] d,
                          input logic ov, input logic ca, input int exp);
    start_word(tag, d, ov, ca, exp);
    pop(tag);
  endtask

  initial begin
    // Reset state while rst is held low.
    #2;
    check("rst:in_ready", in_ready, 1'b0);
    check("rst:out_valid", out_valid, 1'b0);
    check("rst:out_count", {4'd0, out_count}, 8'd0);
    check("rst:out_hit", out_hit, 1'b0);
    check("rst:ser_y", ser_y, 1'b0);
    step();
    step();
    rst = 1'b1;
    #1;
    check("rst:ready_after", in_ready, 1'b1);
    step();

    // Basic match and overlap variants.
    run_word("b0", 8'hB0, 1'b0, 1'b0, 1);
    run_word("b6_ovl", 8'hB6, 1'b1, 1'b0, 2);
    run_word("b6_novl", 8'hB6, 1'b0, 1'b0, 1);

    // Carry across words: 0x05 ends in S101, so the leading 1 of 0x80 matches.
    run_word("carry_05", 8'h05, 1'b0, 1'b1, 0);
    run_word("carry_80", 8'h80, 1'b0, 1'b1, 1);
    run_word("clr_05", 8'h05, 1'b0, 1'b0, 0);
    run_word("clr_80", 8'h80, 1'b0, 1'b0, 0);

    // Backpressure: result holds in DONE and new input is ignored.
    start_word("bp", 8'hB0, 1'b0, 1'b0, 1);
    in_data = 8'hB6; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp:hold_valid", out_valid, 1'b1);
      check("bp:hold_count", {4'd0, out_count}, 8'd1);
      check("bp:hold_ready", in_ready, 1'b0);
    end
    in_valid = 1'b0;
    pop("bp");
    // The word offered under backpressure was not taken.
    run_word("bp_after", 8'h00, 1'b0, 1'b0, 0);

    // Reset mid-word. After 3 bits of 0xBB the detector sits in S101. If
    // that state survived reset, 0xB0 with carry+overlap would count 2.
    in_data = 8'hBB; cfg_overlap = 1'b1; cfg_carry = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step(); step(); step();
    rst = 1'b0;
    #1;
    check("mid_rst:out_valid", out_valid, 1'b0);
    check("mid_rst:in_ready", in_ready, 1'b0);
    check("mid_rst:count", {4'd0, out_count}, 8'd0);
    check("mid_rst:ser_y", ser_y, 1'b0);
    step();
    check("mid_rst:no_result", out_valid, 1'b0);
    rst = 1'b1;
    #1;
    check("mid_rst:ready_after", in_ready, 1'b1);
    step();
    run_word("post_rst_b0", 8'hB0, 1'b1, 1'b1, 1);

    // No matches at all.
    run_word("zeros", 8'h00, 1'b1, 1'b0, 0);
    run_word("ones", 8'hFF, 1'b1, 1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
